// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, long-unit results queue in a
// FIFO, a busy scoreboard flags hazards, and a starvation counter forces WB bubbles.
module regfile_wport_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_ra,
  input  logic [31:0] wb_wd,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_ra,
  input  logic [31:0] lu_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_ra,
  output logic        iss_ok,
  input  logic [4:0]  chk_ra1,
  input  logic [4:0]  chk_ra2,
  output logic        chk_busy,
  output logic        wb_stall,
  output logic        WE3,
  output logic [4:0]  RA3,
  output logic [31:0] WD3,
  output logic        err
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 1 << RW;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [RW-1:0] ra;
    logic [DW-1:0] wd;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [NR-1:0] busy;
  logic [NR-1:0] busy_next;
  logic [SW-1:0] starve_cnt;
  logic          empty;
  logic          push;
  logic          pop;
  logic          iss_set;
  logic          starve_inc;
  logic          starve_hit;
  logic          err_event;

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign lu_ready   = (count < CW'(DEPTH));
  assign push       = lu_valid & lu_ready;
  assign pop        = ~wb_we & ~empty;
  assign iss_ok     = ~busy[iss_ra] | (iss_ra == '0);
  assign iss_set    = iss_valid & iss_ok & (iss_ra != '0);
  assign chk_busy   = busy[chk_ra1] | busy[chk_ra2];
  assign starve_inc = ~empty & wb_we;
  assign starve_hit = starve_inc & (starve_cnt == SW'(STARVE_MAX - 1));
  assign err_event  = (wb_we & wb_stall) | (iss_valid & ~iss_ok);

  // Write-port mux: WB wins, otherwise the FIFO head; r0 never raises WE3
  always_comb begin
    WE3 = 1'b0;
    RA3 = '0;
    WD3 = '0;
    if (wb_we) begin
      WE3 = (wb_ra != '0);
      RA3 = wb_ra;
      WD3 = wb_wd;
    end else if (!empty) begin
      WE3 = (head.ra != '0);
      RA3 = head.ra;
      WD3 = head.wd;
    end
  end

  // Scoreboard update: clear on pop first so a same-cycle issue wins
  always_comb begin
    busy_next = busy;
    if (pop)     busy_next[head.ra] = 1'b0;
    if (iss_set) busy_next[iss_ra]  = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= '{ra: lu_ra, wd: lu_wd};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      busy     <= busy_next;
      wb_stall <= starve_hit;
      err      <= err | err_event;
      if (pop || empty || starve_hit) starve_cnt <= '0;
      else if (starve_inc)            starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: pass-through, queueing, scoreboard,
// starvation bubbles, error flag and reset flush.
module tb_regfile_wport_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        wb_we;
  logic [4:0]  wb_ra;
  logic [31:0] wb_wd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_ra;
  logic [31:0] lu_wd;
  logic        iss_valid;
  logic [4:0]  iss_ra;
  logic        iss_ok;
  logic [4:0]  chk_ra1;
  logic [4:0]  chk_ra2;
  logic        chk_busy;
  logic        wb_stall;
  logic        WE3;
  logic [4:0]  RA3;
  logic [31:0] WD3;
  logic        err;

  int checks   = 0;
  int failures = 0;

  regfile_wport_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .CLK(CLK), .Reset(Reset),
    .wb_we(wb_we), .wb_ra(wb_ra), .wb_wd(wb_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_ra(lu_ra), .lu_wd(lu_wd),
    .iss_valid(iss_valid), .iss_ra(iss_ra), .iss_ok(iss_ok),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_busy(chk_busy),
    .wb_stall(wb_stall), .WE3(WE3), .RA3(RA3), .WD3(WD3), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; checks follow 1 unit later, before negedge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; wb_we = 1'b0; wb_ra = '0; wb_wd = '0;
    lu_valid = 1'b0; lu_ra = '0; lu_wd = '0;
    iss_valid = 1'b0; iss_ra = '0; chk_ra1 = '0; chk_ra2 = '0;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    check("rst_lu_ready", 32'(lu_ready), 32'd1);
    check("rst_we3",      32'(WE3),      32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_stall",    32'(wb_stall), 32'd0);

    // 1: WB pass-through, same cycle
    wb_we = 1'b1; wb_ra = 5'd5; wb_wd = 32'h1234; chk_ra1 = 5'd5; chk_ra2 = 5'd8;
    #1;
    check("t1_we3",  32'(WE3), 32'd1);
    check("t1_ra3",  32'(RA3), 32'd5);
    check("t1_wd3",  WD3,      32'h1234);
    check("t1_busy", 32'(chk_busy), 32'd0);

    // 2: issue r8, then long-unit result for r8
    tick();
    wb_we = 1'b0; iss_valid = 1'b1; iss_ra = 5'd8; chk_ra1 = 5'd8; chk_ra2 = 5'd0;
    #1;
    check("t2_iss_ok", 32'(iss_ok), 32'd1);
    tick();
    iss_valid = 1'b0; lu_valid = 1'b1; lu_ra = 5'd8; lu_wd = 32'hAA;
    #1;
    check("t2_busy_set", 32'(chk_busy), 32'd1);
    check("t2_no_early", 32'(WE3),      32'd0);
    tick();
    lu_valid = 1'b0;
    #1;
    check("t2_we3",       32'(WE3),      32'd1);
    check("t2_ra3",       32'(RA3),      32'd8);
    check("t2_wd3",       WD3,           32'hAA);
    check("t2_busy_hold", 32'(chk_busy), 32'd1);
    tick();
    #1;
    check("t2_busy_clr", 32'(chk_busy), 32'd0);
    check("t2_empty",    32'(WE3),      32'd0);

    // 3: fill FIFO under continuous WB traffic; bubble 8 cycles after first push
    for (int c = 0; c < 9; c++) begin
      wb_we = 1'b1; wb_ra = 5'd1; wb_wd = 32'h100 + 32'(c);
      lu_valid = (c < 5); lu_ra = 5'(10 + c); lu_wd = 32'hB0 + 32'(c);
      #1;
      if (c < 4)  check("t3_ready", 32'(lu_ready), 32'd1);
      if (c == 4) check("t3_full",  32'(lu_ready), 32'd0);
      if (c == 5) check("t3_no_err_hold", 32'(err), 32'd0);
      if (c == 8) check("t3_no_stall_yet", 32'(wb_stall), 32'd0);
      tick();
    end
    lu_valid = 1'b0; wb_we = 1'b0;
    #1;
    check("t3_stall",    32'(wb_stall), 32'd1);
    check("t3_drain_ra", 32'(RA3),      32'd10);
    check("t3_drain_wd", WD3,           32'hB0);
    check("t3_drain_we", 32'(WE3),      32'd1);
    tick();
    for (int c = 10; c < 18; c++) begin
      wb_we = 1'b1; wb_ra = 5'd1; wb_wd = 32'h200 + 32'(c);
      #1;
      if (c == 10) begin
        check("t3_stall_1cyc", 32'(wb_stall), 32'd0);
        check("t3_ready_back", 32'(lu_ready), 32'd1);
        check("t3_wb_wins",    32'(RA3),      32'd1);
      end
      tick();
    end
    wb_we = 1'b0;
    #1;
    check("t3_stall2",    32'(wb_stall), 32'd1);
    check("t3_drain2_ra", 32'(RA3),      32'd11);
    check("t3_drain2_wd", WD3,           32'hB1);
    tick();
    #1;
    check("t3_drain3_ra", 32'(RA3), 32'd12);
    tick();
    #1;
    check("t3_drain4_ra", 32'(RA3), 32'd13);
    tick();
    #1;
    check("t3_fifo_empty", 32'(WE3), 32'd0);

    // 4: re-issue to a busy register, error flag, r0 write suppressed
    iss_valid = 1'b1; iss_ra = 5'd3;
    #1;
    check("t4_iss_ok_first", 32'(iss_ok), 32'd1);
    tick();
    #1;
    check("t4_iss_ok_busy", 32'(iss_ok), 32'd0);
    check("t4_err_before",  32'(err),    32'd0);
    tick();
    iss_valid = 1'b0; wb_we = 1'b1; wb_ra = 5'd0; wb_wd = 32'hFFFF;
    #1;
    check("t4_err_set", 32'(err), 32'd1);
    check("t4_r0_we3",  32'(WE3), 32'd0);

    // 5: pop of r9 coincident with issue of r9 keeps r9 busy
    tick();
    wb_we = 1'b0; lu_valid = 1'b1; lu_ra = 5'd9; lu_wd = 32'h99;
    tick();
    lu_valid = 1'b0; iss_valid = 1'b1; iss_ra = 5'd9;
    #1;
    check("t5_iss_ok", 32'(iss_ok), 32'd1);
    check("t5_pop_ra", 32'(RA3),    32'd9);
    tick();
    iss_valid = 1'b0; chk_ra1 = 5'd9; chk_ra2 = 5'd0;
    #1;
    check("t5_busy9", 32'(chk_busy), 32'd1);
    check("t5_empty", 32'(WE3),      32'd0);

    // 6: reset with three queued entries flushes everything
    for (int c = 0; c < 3; c++) begin
      wb_we = 1'b1; wb_ra = 5'd2; lu_valid = 1'b1; lu_ra = 5'(20 + c); lu_wd = 32'(c);
      tick();
    end
    lu_valid = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0; wb_we = 1'b0; chk_ra1 = 5'd3; chk_ra2 = 5'd9;
    #1;
    check("t6_ready", 32'(lu_ready), 32'd1);
    check("t6_we3",   32'(WE3),      32'd0);
    check("t6_err",   32'(err),      32'd0);
    check("t6_busy",  32'(chk_busy), 32'd0);
    check("t6_stall", 32'(wb_stall), 32'd0);
    tick();
    #1;
    check("t6_still_empty", 32'(WE3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
